nexys_starship_repair_lock: RTL
===============================

// Module: nexys_starship_repair_lock
// PURPOSE
//  Consumer of the switch-combo entries captured on the centre-button pulse: checks hex combos against a
//  pseudo-random repair code per broken ship side. Sits between the debounced button/switch capture and
//  the side monster SMs. Raises a one-cycle repaired pulse on a correct entry. Limits wrong tries, then
//  enforces a timed lockout. Exports the live code for SSD display.
// PARAMETERS
//  CODE_SEED       8'hA5        LFSR seed; must be nonzero
//  MAX_TRIES       3            wrong entries allowed per code, 1..3
//  LOCKOUT_CYCLES  100_000_000  lockout length in Clk cycles (1 s at 100 MHz), >=2
// PORTS
//  Clk          in   1  system clock, 100 MHz
//  Reset        in   1  asynchronous, active-high reset
//  broken       in   1  level: this side needs repair
//  game_over    in   1  level: abort everything, hold IDLE
//  combo_valid  in   1  one-cycle entry strobe (centre pulse)
//  combo_in     in   4  {Sw3,Sw2,Sw1,Sw0} sampled with combo_valid
//  code_out     out  4  active repair code; 0 outside ARMED/LOCKOUT
//  code_valid   out  1  1 in ARMED only
//  repaired     out  1  one-cycle pulse, correct entry
//  wrong        out  1  one-cycle pulse, incorrect entry
//  tries_left   out  2  remaining tries; 0 outside ARMED
//  q_Init, q_Idle, q_Armed, q_Lockout, q_Done  out 1 each  one-hot state flags
// BEHAVIOUR
//  Reset: state INIT; LFSR=CODE_SEED; code_out=0; code_valid=0; repaired=0; wrong=0; tries_left=0;
//   lockout counter=0.
//  LFSR: 8-bit Galois, x^8+x^6+x^5+x^4+1; advances every Clk regardless of state.
//  All outputs registered; each response appears the cycle after its cause.
//  INIT -> IDLE unconditionally after one cycle.
//  IDLE: broken=1 & game_over=0 -> ARMED. Latch code=lfsr[3:0] and tries=MAX_TRIES.
//   combo_valid is ignored in IDLE, including the cycle broken rises.
//  ARMED, on combo_valid:
//   - combo_in==code -> repaired=1, -> DONE.
//   - otherwise -> wrong=1, tries-=1.
//   - if tries reaches 0 -> LOCKOUT; load counter=LOCKOUT_CYCLES-1; tries_left=0.
//  ARMED, broken falls without an entry -> IDLE, no pulse.
//  LOCKOUT: counter decrements each cycle; combo_valid ignored (also on the expiry cycle).
//   code_valid=0; code_out holds the old code. At counter==0 -> ARMED with new code=lfsr[3:0] and
//   tries=MAX_TRIES. If broken=0 at expiry -> IDLE instead.
//  DONE: hold until broken=0, then -> IDLE. A re-break later arms a fresh code.
//  game_over=1: from any state, next state IDLE. Clears code/tries/counter; no pulses that cycle.
//  Priority within one cycle: Reset > game_over > broken-fall > combo_valid > lockout expiry.
//  repaired and wrong are never both 1. Neither is asserted outside an ARMED-state entry.
//  Async Reset mid-LOCKOUT or mid-ARMED: immediate return to reset values; no pulse emitted.
// STRUCTURE
//  Shared package nexys_starship_pkg: state encodings (INIT, IDLE, ARMED, LOCKOUT, DONE),
//   LFSR tap constant, default LOCKOUT_CYCLES.
//  Sub-module nexys_starship_lfsr8 (Clk, Reset, seed -> value[7:0]); FSM, try counter and lockout
//   counter stay in this module.
//  Top instantiates one lock per side. code_out muxes into SSD digit scan; repaired clears the side's
//   broken in the monster SM.
// TESTING (bench: LOCKOUT_CYCLES=16, MAX_TRIES=3)
//  1 Reset then release -> q_Init 1 cycle, then q_Idle=1; all data outputs 0; LFSR sequence matches
//    a golden model from 8'hA5.
//  2 broken=1; after arming read C=code_out; combo_valid with combo_in=C -> repaired=1 for exactly one
//    cycle, q_Done=1; broken=0 -> q_Idle.
//  3 Armed code C; three entries of C^4'h1 -> wrong pulses; tries_left 3->2->1->0; q_Lockout on 3rd.
//    Entry of C in lockout -> no pulse. After 16 cycles -> q_Armed, tries_left=3, code_out=new lfsr[3:0].
//  4 broken and combo_valid rise in the same cycle in IDLE -> no pulse; next-cycle entry of correct code
//    -> repaired.
//  5 game_over=1 mid-LOCKOUT (counter=8) -> IDLE next cycle; code_out=0; counter cleared; no
//    repaired/wrong pulses.
//  6 Reset asserted mid-ARMED with tries_left=1 -> outputs return to reset values asynchronously;
//    behaviour after release identical to scenario 1.

Source files
------------

// File: rtl/nexys_starship_pkg.sv
// Shared types and constants for the starship repair-lock block.
package nexys_starship_pkg;

    // One-hot encoding so the q_* state flags come straight off the register.
    typedef enum logic [4:0] {
        ST_INIT    = 5'b00001,
        ST_IDLE    = 5'b00010,
        ST_ARMED   = 5'b00100,
        ST_LOCKOUT = 5'b01000,
        ST_DONE    = 5'b10000
    } lock_state_e;

    // Right-shift Galois mask for x^8 + x^6 + x^5 + x^4 + 1.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // 1 s at 100 MHz.
    localparam int unsigned LOCKOUT_CYCLES_DEF = 100_000_000;

    function automatic logic [7:0] lfsr8_next(input logic [7:0] v);
        return {1'b0, v[7:1]} ^ (v[0] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/nexys_starship_lfsr8.sv
// Free-running 8-bit Galois LFSR; supplies the pseudo-random repair codes.
module nexys_starship_lfsr8
    import nexys_starship_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] seed,
    output logic [7:0] value
);

    logic [7:0] value_q;

    // Advance every cycle regardless of what the lock is doing.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) value_q <= seed;
        else       value_q <= lfsr8_next(value_q);
    end

    assign value = value_q;

endmodule

// File: rtl/nexys_starship_repair_lock.sv
// Repair-code lock for one ship side: arms a code when the side breaks, checks
// switch entries, pulses repaired/wrong, and imposes a timed lockout after too
// many wrong tries.
//
// state   | meaning
// INIT    | first cycle after reset
// IDLE    | side healthy or game over; waiting for broken
// ARMED   | code live, accepting entries
// LOCKOUT | too many wrong entries; entries ignored until timer expires
// DONE    | repaired; waiting for broken to drop
module nexys_starship_repair_lock
    import nexys_starship_pkg::*;
#(
    parameter logic [7:0]  CODE_SEED      = 8'hA5,
    parameter int          MAX_TRIES      = 3,
    parameter int unsigned LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       broken,
    input  logic       game_over,
    input  logic       combo_valid,
    input  logic [3:0] combo_in,
    output logic [3:0] code_out,
    output logic       code_valid,
    output logic       repaired,
    output logic       wrong,
    output logic [1:0] tries_left,
    output logic       q_Init,
    output logic       q_Idle,
    output logic       q_Armed,
    output logic       q_Lockout,
    output logic       q_Done
);

    localparam int             CNT_W      = $clog2(LOCKOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]     TRIES_INIT = 2'(MAX_TRIES);

    lock_state_e      state_q, state_d;
    logic [3:0]       code_q, code_d;
    logic [1:0]       tries_q, tries_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rep_q, rep_d;
    logic             wrong_q, wrong_d;
    logic             cvalid_q, cvalid_d;

    logic [7:0] lfsr_value;
    logic       unused_lfsr_hi;

    nexys_starship_lfsr8 u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .seed  (CODE_SEED),
        .value (lfsr_value)
    );

    // Only the low nibble forms a code.
    assign unused_lfsr_hi = ^lfsr_value[7:4];

    // State, code, tries, lockout timer and output pulses.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_INIT;
            code_q   <= '0;
            tries_q  <= '0;
            cnt_q    <= '0;
            rep_q    <= 1'b0;
            wrong_q  <= 1'b0;
            cvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            tries_q  <= tries_d;
            cnt_q    <= cnt_d;
            rep_q    <= rep_d;
            wrong_q  <= wrong_d;
            cvalid_q <= cvalid_d;
        end
    end

    // Next-state logic; code/tries are zeroed whenever the state leaves the
    // range where they are displayed, so the outputs need no extra masking.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        tries_d = tries_q;
        cnt_d   = cnt_q;
        rep_d   = 1'b0;
        wrong_d = 1'b0;
        if (game_over) begin
            state_d = ST_IDLE;
            code_d  = '0;
            tries_d = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_INIT: state_d = ST_IDLE;
                ST_IDLE: begin
                    if (broken) begin
                        state_d = ST_ARMED;
                        code_d  = lfsr_value[3:0];
                        tries_d = TRIES_INIT;
                    end
                end
                ST_ARMED: begin
                    if (!broken) begin
                        state_d = ST_IDLE;
                        code_d  = '0;
                        tries_d = '0;
                    end else if (combo_valid) begin
                        if (combo_in == code_q) begin
                            rep_d   = 1'b1;
                            state_d = ST_DONE;
                            code_d  = '0;
                            tries_d = '0;
                        end else begin
                            wrong_d = 1'b1;
                            if (tries_q <= 2'd1) begin
                                state_d = ST_LOCKOUT;
                                tries_d = '0;
                                cnt_d   = CNT_LOAD;
                            end else begin
                                tries_d = tries_q - 2'd1;
                            end
                        end
                    end
                end
                ST_LOCKOUT: begin
                    // The penalty always runs to completion; broken is only
                    // consulted when the timer expires.
                    if (cnt_q == '0) begin
                        if (broken) begin
                            state_d = ST_ARMED;
                            code_d  = lfsr_value[3:0];
                            tries_d = TRIES_INIT;
                        end else begin
                            state_d = ST_IDLE;
                            code_d  = '0;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!broken) state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    code_d  = '0;
                    tries_d = '0;
                    cnt_d   = '0;
                end
            endcase
        end
        cvalid_d = (state_d == ST_ARMED);
    end

    assign code_out   = code_q;
    assign code_valid = cvalid_q;
    assign repaired   = rep_q;
    assign wrong      = wrong_q;
    assign tries_left = tries_q;
    assign q_Init     = state_q[0];
    assign q_Idle     = state_q[1];
    assign q_Armed    = state_q[2];
    assign q_Lockout  = state_q[3];
    assign q_Done     = state_q[4];

endmodule
